muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_unit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// Request/response and HI/LO write bundle for muldiv_unit.
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] In1;
  logic [31:0] In2;
  logic        wrHi;
  logic        wrLo;
  logic [31:0] wrData;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        divZero;

  modport master (
    output start, op, In1, In2, wrHi, wrLo, wrData,
    input  busy, done, hi, lo, divZero
  );

  modport slave (
    input  start, op, In1, In2, wrHi, wrLo, wrData,
    output busy, done, hi, lo, divZero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide with HI/LO result registers.
// One bit per cycle for 32 cycles, with signs applied on completion.
module muldiv_unit (
  input logic      clk,
  input logic      rst,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] acc_q, acc_d;

  logic        signed_op;
  logic [31:0] mag1, mag2;
  logic [32:0] sum, shifted, diff;
  logic [63:0] step, prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;

    signed_op = ~bus.op[0];
    mag1 = (signed_op && bus.In1[31]) ? (~bus.In1 + 32'd1) : bus.In1;
    mag2 = (signed_op && bus.In2[31]) ? (~bus.In2 + 32'd1) : bus.In2;

    // acc holds {partial product, multiplier} for multiply and
    // {remainder, dividend/quotient} for divide; both shift one bit per cycle.
    sum     = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    shifted = acc_q[63:31];
    diff    = shifted - {1'b0, opnd_q};
    if (is_div_q) begin
      step = diff[32] ? {acc_q[62:0], 1'b0} : {diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      step = {sum, acc_q[31:1]};
    end
    prod_fix = neg_q  ? (~step + 64'd1)         : step;
    quo_fix  = neg_q  ? (~step[31:0] + 32'd1)   : step[31:0];
    rem_fix  = rneg_q ? (~step[63:32] + 32'd1)  : step[63:32];

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_d    = '0;
          dz_d     = 1'b0;
          is_div_d = bus.op[1];
          neg_d    = signed_op & (bus.In1[31] ^ bus.In2[31]);
          rneg_d   = signed_op & bus.In1[31];
          if (bus.op[1] && (bus.In2 == '0)) begin
            state_d = DONE;
            hi_d    = bus.In1;
            lo_d    = '1;
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
            opnd_d  = bus.op[1] ? mag2 : mag1;
            acc_d   = bus.op[1] ? {32'd0, mag1} : {32'd0, mag2};
          end
        end else begin
          if (bus.wrHi) hi_d = bus.wrData;
          if (bus.wrLo) lo_d = bus.wrData;
        end
      end
      RUN: begin
        acc_d = step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.divZero = dz_q;

endmodule
